// File: rtl/lc3_uart_mmio.sv
// LC-3 console device: KBSR/KBDR/DSR/DDR registers bridging the core bus to
// the UART helper byte streams, with a small receive FIFO and one-byte transmit holding register.
module lc3_uart_mmio #(
  parameter int          RX_DEPTH  = 4,
  parameter logic [15:0] BASE_ADDR = 16'hFE00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bus_addr,
  input  logic        bus_ren,
  input  logic        bus_wen,
  input  logic [15:0] bus_wdata,
  output logic [15:0] bus_rdata,
  output logic        bus_sel,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(RX_DEPTH);
  localparam logic [15:0]   KBSR_ADDR = BASE_ADDR;
  localparam logic [15:0]   KBDR_ADDR = BASE_ADDR + 16'd2;
  localparam logic [15:0]   DSR_ADDR  = BASE_ADDR + 16'd4;
  localparam logic [15:0]   DDR_ADDR  = BASE_ADDR + 16'd6;

  logic [7:0]    rx_mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          tx_full_q, tx_full_d;
  logic [7:0]    tx_buf_q, tx_buf_d;
  logic          kb_ie_q, kb_ie_d;
  logic          ds_ie_q, ds_ie_d;
  logic          tx_drop_q, tx_drop_d;

  logic hit_kbsr, hit_kbdr, hit_dsr, hit_ddr;
  logic rx_empty, rx_full, push, pop;
  logic tx_hs, ddr_wr, ddr_accept, drop_set;
  logic unused_wdata;

  assign hit_kbsr = (bus_addr == KBSR_ADDR);
  assign hit_kbdr = (bus_addr == KBDR_ADDR);
  assign hit_dsr  = (bus_addr == DSR_ADDR);
  assign hit_ddr  = (bus_addr == DDR_ADDR);
  assign bus_sel  = hit_kbsr | hit_kbdr | hit_dsr | hit_ddr;

  assign rx_empty = (count_q == '0);
  assign rx_full  = (count_q == DEPTH_C);
  assign rx_ready = !rx_full;
  assign push     = rx_valid && rx_ready;
  assign pop      = bus_ren && hit_kbdr && !rx_empty;

  assign tx_valid   = tx_full_q;
  assign tx_data    = tx_buf_q;
  assign tx_hs      = tx_full_q && tx_ready;
  assign ddr_wr     = bus_wen && hit_ddr;
  // A write landing in the handshake cycle refills the buffer rather than dropping.
  assign ddr_accept = ddr_wr && (!tx_full_q || tx_hs);
  assign drop_set   = ddr_wr && tx_full_q && !tx_hs;

  assign irq = (kb_ie_q && !rx_empty) || (ds_ie_q && !tx_full_q);

  assign unused_wdata = ^{bus_wdata[15], bus_wdata[13:8]};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    tx_full_d = tx_full_q;
    tx_buf_d  = tx_buf_q;
    kb_ie_d   = kb_ie_q;
    ds_ie_d   = ds_ie_q;
    tx_drop_d = tx_drop_q;
    if (ddr_accept) begin
      tx_full_d = 1'b1;
      tx_buf_d  = bus_wdata[7:0];
    end else if (tx_hs) begin
      tx_full_d = 1'b0;
    end
    if (drop_set) tx_drop_d = 1'b1;
    if (bus_wen && hit_kbsr) kb_ie_d = bus_wdata[14];
    if (bus_wen && hit_dsr) begin
      ds_ie_d = bus_wdata[14];
      if (bus_wdata[0]) tx_drop_d = 1'b0;
    end
  end

  // Read data reflects register state before any same-cycle write.
  always_comb begin
    bus_rdata = 16'h0000;
    if (bus_ren) begin
      if (hit_kbsr)
        bus_rdata = {!rx_empty, kb_ie_q, 14'b0};
      else if (hit_kbdr && !rx_empty)
        bus_rdata = {8'h00, rx_mem[rd_ptr_q]};
      else if (hit_dsr)
        bus_rdata = {!tx_full_q, ds_ie_q, 13'b0, tx_drop_q};
    end
  end

  always_ff @(posedge clk) begin
    if (push) rx_mem[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_full_q <= 1'b0;
      tx_buf_q  <= 8'h00;
      kb_ie_q   <= 1'b0;
      ds_ie_q   <= 1'b0;
      tx_drop_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_full_q <= tx_full_d;
      tx_buf_q  <= tx_buf_d;
      kb_ie_q   <= kb_ie_d;
      ds_ie_q   <= ds_ie_d;
      tx_drop_q <= tx_drop_d;
    end
  end

endmodule
